// File: rtl/segment_scan_driver_pkg.sv
// segment_scan_pkg: shared width, slot phase type and parameter legality rule
package segment_scan_pkg;
   localparam int SEG_W = 8;
   typedef enum logic {BLANK, SHOW} phase_t;
   function automatic bit params_ok(int n, int p, int b);
      return n >= 1 && n <= 8 && p >= 2 && b >= 0 && b < p;
   endfunction
endpackage

// File: rtl/segment_scan_driver_if.sv
// segment_scan_driver_if: pattern load bus and scan outputs
//   load/seg_in from master; seg_out, digit_en, frame_done, update_pending from slave
interface segment_scan_driver_if #(parameter int NUM_DIGITS = 4);
   import segment_scan_pkg::*;
   logic load;
   logic [SEG_W*NUM_DIGITS-1:0] seg_in;
   logic [SEG_W-1:0] seg_out;
   logic [NUM_DIGITS-1:0] digit_en;
   logic frame_done;
   logic update_pending;
   modport master (output load, seg_in, input seg_out, digit_en, frame_done, update_pending);
   modport slave (input load, seg_in, output seg_out, digit_en, frame_done, update_pending);
endinterface

// File: rtl/segment_scan_driver_slot_timer.sv
// slot_timer: cycle-in-slot counter and digit index
//   slot_phase/idx describe the coming cycle so the top can register its outputs
//   boundary is high in the current last cycle of a frame
module slot_timer #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE = 50000,
   parameter int BLANK = 16,
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
   input logic clk,
   input logic rst,
   output segment_scan_pkg::phase_t slot_phase,
   output logic boundary,
   output logic [IW-1:0] idx
);
   import segment_scan_pkg::*;
   localparam int CW = $clog2(PRESCALE);
   logic [CW-1:0] cnt, cnt_n;
   logic [IW-1:0] cur_idx, idx_n;
   logic last;
   always_comb begin
      last = cnt == CW'(PRESCALE - 1);
      boundary = last && cur_idx == IW'(NUM_DIGITS - 1);
      cnt_n = last ? '0 : cnt + CW'(1);
      idx_n = boundary ? '0 : cur_idx + IW'(last);
      slot_phase = cnt_n < CW'(BLANK) ? segment_scan_pkg::BLANK : segment_scan_pkg::SHOW;
   end
   assign idx = idx_n;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         cur_idx <= '0;
      end else begin
         cnt <= cnt_n;
         cur_idx <= idx_n;
      end
   end
endmodule

// File: rtl/segment_scan_driver.sv
// segment_scan_driver: time-multiplexed seven-segment scanner with frame-atomic updates
//   clk, rst: clock and synchronous active-high reset
//   bus (slave): load/seg_in capture, seg_out/digit_en scan, frame_done, update_pending
module segment_scan_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE = 50000,
   parameter int BLANK = 16,
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
   input logic clk,
   input logic rst,
   segment_scan_driver_if.slave bus
);
   import segment_scan_pkg::*;
   if (!params_ok(NUM_DIGITS, PRESCALE, BLANK)) begin : g_bad_params
      $error("segment_scan_driver: illegal NUM_DIGITS/PRESCALE/BLANK");
   end
   phase_t ph;
   logic boundary;
   logic [IW-1:0] idx;
   logic pending;
   logic [NUM_DIGITS-1:0][SEG_W-1:0] shadow, active, active_n;
   slot_timer #(.NUM_DIGITS(NUM_DIGITS), .PRESCALE(PRESCALE), .BLANK(BLANK)) u_timer (
      .clk(clk), .rst(rst), .slot_phase(ph), .boundary(boundary), .idx(idx)
   );
   // a load in the boundary cycle bypasses shadow so it shows one cycle later
   always_comb active_n = boundary ? (bus.load ? bus.seg_in : pending ? shadow : active) : active;
   assign bus.update_pending = pending;
   // outputs are registered from look-ahead timer values and active_n so they match the current cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
         active <= '0;
         pending <= 1'b0;
         bus.seg_out <= '0;
         bus.digit_en <= '0;
         bus.frame_done <= 1'b0;
      end else begin
         if (bus.load) shadow <= bus.seg_in;
         pending <= !boundary && (pending || bus.load);
         active <= active_n;
         bus.frame_done <= boundary;
         bus.digit_en <= ph == SHOW ? NUM_DIGITS'(1) << idx : '0;
         bus.seg_out <= ph == SHOW ? active_n[idx] : '0;
      end
   end
endmodule

// File: tb/tb_segment_scan_driver.sv
// tb_segment_scan_driver: scenario tasks checked against a frame-level display model
module tb_segment_scan_driver;
   localparam int N = 4, P = 8, B = 2, F = N * P;
   logic clk = 0, rst = 1;
   int errors = 0, checks = 0;
   int t;
   logic [31:0] cur, pdat, d_q;
   bit pend, ld_q;
   segment_scan_driver_if #(.NUM_DIGITS(N)) bus();
   segment_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK(B)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   // advance the model over the closing cycle, then drive the next one and stop at its negedge
   task automatic go(input bit r, input bit ld, input logic [31:0] d);
      @(posedge clk);
      if (rst) begin
         t = 0; cur = 0; pend = 0;
      end else begin
         if (t % F == F - 1) begin
            if (ld_q) cur = d_q;
            else if (pend) cur = pdat;
            pend = 0;
         end else if (ld_q) begin
            pend = 1; pdat = d_q;
         end
         t++;
      end
      #1 rst = r; bus.load = ld; bus.seg_in = d; ld_q = ld; d_q = d;
      @(negedge clk);
   endtask

   function automatic logic [N-1:0] e_en();
      return (t % P < B) ? '0 : N'(1) << ((t % F) / P);
   endfunction
   function automatic logic [7:0] e_seg();
      return (t % P < B) ? 8'h00 : 8'(cur >> (8 * ((t % F) / P)));
   endfunction
   function automatic logic e_fd();
      return t > 0 && t % F == 0;
   endfunction

   task automatic do_reset();
      go(1, 0, 0);
      go(1, 0, 0);
   endtask

   task automatic test_reset();
      logic [N-1:0] el;
      for (int i = 0; i < 3; i++) begin
         go(1, 0, 0);
         checks++;
         if ({bus.seg_out, bus.digit_en, bus.frame_done, bus.update_pending} !== '0) begin
            errors++; $display("FAIL reset_outputs cyc=%0d got=%h/%b/%b/%b exp=0", i, bus.seg_out, bus.digit_en, bus.frame_done, bus.update_pending);
         end
      end
      for (int c = 0; c < 36; c++) begin
         go(0, 0, 0);
         checks += 4;
         if (bus.digit_en !== e_en()) begin errors++; $display("FAIL scan_en t=%0d got=%b exp=%b", t, bus.digit_en, e_en()); end
         if (bus.seg_out !== e_seg()) begin errors++; $display("FAIL scan_seg t=%0d got=%h exp=%h", t, bus.seg_out, e_seg()); end
         if (bus.frame_done !== e_fd()) begin errors++; $display("FAIL scan_fd t=%0d got=%b exp=%b", t, bus.frame_done, e_fd()); end
         if (bus.update_pending !== 1'b0) begin errors++; $display("FAIL scan_up t=%0d got=%b exp=0", t, bus.update_pending); end
         if (c inside {0, 1, 2, 10, 26, 34}) begin
            el = c < 2 ? 4'b0000 : c == 10 ? 4'b0010 : c == 26 ? 4'b1000 : 4'b0001;
            checks++;
            if (bus.digit_en !== el || bus.seg_out !== 8'h00) begin errors++; $display("FAIL scan_fixed c=%0d got=%b/%h exp=%b/00", c, bus.digit_en, bus.seg_out, el); end
         end
         if (c == 32) begin
            checks++;
            if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL scan_fd32 got=%b exp=1", bus.frame_done); end
         end
      end
   endtask

   task automatic test_mid_load();
      logic [7:0] es;
      do_reset();
      for (int c = 0; c < 72; c++) begin
         go(0, c == 5, c == 5 ? 32'h3F065B4F : 32'h0);
         checks += 4;
         if (bus.digit_en !== e_en()) begin errors++; $display("FAIL mid_en t=%0d got=%b exp=%b", t, bus.digit_en, e_en()); end
         if (bus.seg_out !== e_seg()) begin errors++; $display("FAIL mid_seg t=%0d got=%h exp=%h", t, bus.seg_out, e_seg()); end
         if (bus.frame_done !== e_fd()) begin errors++; $display("FAIL mid_fd t=%0d got=%b exp=%b", t, bus.frame_done, e_fd()); end
         if (bus.update_pending !== pend) begin errors++; $display("FAIL mid_up t=%0d got=%b exp=%b", t, bus.update_pending, pend); end
         checks++;
         if (bus.update_pending !== (c >= 6 && c <= 31)) begin errors++; $display("FAIL mid_up_fixed c=%0d got=%b", c, bus.update_pending); end
         if (c <= 33) begin
            checks++;
            if (bus.seg_out !== 8'h00) begin errors++; $display("FAIL mid_early c=%0d got=%h exp=00", c, bus.seg_out); end
         end
         if (c == 32) begin
            checks++;
            if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL mid_fd32 got=%b exp=1", bus.frame_done); end
         end
         if (c inside {34, 42, 50, 58}) begin
            es = c == 34 ? 8'h4F : c == 42 ? 8'h5B : c == 50 ? 8'h06 : 8'h3F;
            checks++;
            if (bus.seg_out !== es) begin errors++; $display("FAIL mid_digit c=%0d got=%h exp=%h", c, bus.seg_out, es); end
         end
      end
   endtask

   task automatic test_last_wins();
      do_reset();
      for (int c = 0; c < 64; c++) begin
         go(0, c == 3 || c == 20, c == 3 ? 32'h06060606 : c == 20 ? 32'h7F7F7F7F : 32'h0);
         checks += 4;
         if (bus.digit_en !== e_en()) begin errors++; $display("FAIL lw_en t=%0d got=%b exp=%b", t, bus.digit_en, e_en()); end
         if (bus.seg_out !== e_seg()) begin errors++; $display("FAIL lw_seg t=%0d got=%h exp=%h", t, bus.seg_out, e_seg()); end
         if (bus.frame_done !== e_fd()) begin errors++; $display("FAIL lw_fd t=%0d got=%b exp=%b", t, bus.frame_done, e_fd()); end
         if (bus.update_pending !== pend) begin errors++; $display("FAIL lw_up t=%0d got=%b exp=%b", t, bus.update_pending, pend); end
         checks++;
         if (bus.seg_out === 8'h06) begin errors++; $display("FAIL lw_stale c=%0d got=06 exp=not 06", c); end
         if (c >= 32 && bus.digit_en !== '0) begin
            checks++;
            if (bus.seg_out !== 8'h7F) begin errors++; $display("FAIL lw_new c=%0d got=%h exp=7F", c, bus.seg_out); end
         end
      end
   endtask

   task automatic test_boundary_load();
      do_reset();
      for (int c = 0; c < 44; c++) begin
         go(0, c == 31, c == 31 ? 32'h6D6D6D6D : 32'h0);
         checks += 3;
         if (bus.digit_en !== e_en()) begin errors++; $display("FAIL bl_en t=%0d got=%b exp=%b", t, bus.digit_en, e_en()); end
         if (bus.seg_out !== e_seg()) begin errors++; $display("FAIL bl_seg t=%0d got=%h exp=%h", t, bus.seg_out, e_seg()); end
         if (bus.update_pending !== 1'b0) begin errors++; $display("FAIL bl_up c=%0d got=%b exp=0", c, bus.update_pending); end
         if (c == 33 || c == 34) begin
            checks++;
            if (bus.seg_out !== (c == 34 ? 8'h6D : 8'h00)) begin errors++; $display("FAIL bl_show c=%0d got=%h", c, bus.seg_out); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d = $urandom;
      do_reset();
      for (int c = 0; c <= 20; c++) begin
         go(c == 20, c == 10, c == 10 ? d : 32'h0);
         checks += 2;
         if (bus.seg_out !== e_seg()) begin errors++; $display("FAIL rm_seg t=%0d got=%h exp=%h", t, bus.seg_out, e_seg()); end
         if (bus.update_pending !== pend) begin errors++; $display("FAIL rm_up t=%0d got=%b exp=%b", t, bus.update_pending, pend); end
      end
      for (int c = 21; c < 53; c++) begin
         go(0, 0, 0);
         checks += 2;
         if (bus.digit_en !== e_en()) begin errors++; $display("FAIL rm_en c=%0d got=%b exp=%b", c, bus.digit_en, e_en()); end
         if ({bus.seg_out, bus.frame_done, bus.update_pending} !== '0) begin
            errors++; $display("FAIL rm_clear c=%0d got=%h/%b/%b exp=0", c, bus.seg_out, bus.frame_done, bus.update_pending);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] seen [N];
      bit sv [N];
      bit ld;
      for (int k = 0; k < N; k++) sv[k] = 0;
      do_reset();
      for (int c = 0; c < 10 * F; c++) begin
         ld = $urandom_range(0, 5) == 0 || c == 95;
         go(0, ld, ld ? $urandom : 32'h0);
         checks += 6;
         if (bus.digit_en !== e_en()) begin errors++; $display("FAIL rnd_en t=%0d got=%b exp=%b", t, bus.digit_en, e_en()); end
         if (bus.seg_out !== e_seg()) begin errors++; $display("FAIL rnd_seg t=%0d got=%h exp=%h", t, bus.seg_out, e_seg()); end
         if (bus.frame_done !== e_fd()) begin errors++; $display("FAIL rnd_fd t=%0d got=%b exp=%b", t, bus.frame_done, e_fd()); end
         if (bus.update_pending !== pend) begin errors++; $display("FAIL rnd_up t=%0d got=%b exp=%b", t, bus.update_pending, pend); end
         if (!$onehot0(bus.digit_en)) begin errors++; $display("FAIL rnd_onehot t=%0d got=%b exp=onehot0", t, bus.digit_en); end
         if (bus.digit_en === '0 && bus.seg_out !== 8'h00) begin errors++; $display("FAIL rnd_dark t=%0d got=%h exp=00", t, bus.seg_out); end
         if (bus.frame_done) for (int k = 0; k < N; k++) sv[k] = 0;
         for (int k = 0; k < N; k++) if (bus.digit_en[k]) begin
            if (sv[k]) begin
               checks++;
               if (bus.seg_out !== seen[k]) begin errors++; $display("FAIL rnd_midframe t=%0d digit=%0d got=%h exp=%h", t, k, bus.seg_out, seen[k]); end
            end
            sv[k] = 1; seen[k] = bus.seg_out;
         end
      end
   endtask

   initial begin
      bus.load = 0;
      bus.seg_in = '0;
      ld_q = 0; d_q = 0; t = 0; cur = 0; pend = 0; pdat = 0;
      test_reset();
      test_mid_load();
      test_last_wins();
      test_boundary_load();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
